// File: rtl/prog_loader.sv
// Boot loader: receives a framed, checksummed byte stream, writes it into program memory
// and holds the cpu in reset until a verified image has been loaded.
module prog_loader #(
  parameter int unsigned          ADDR_W    = 13,
  parameter logic [7:0]           SYNC      = 8'hA5,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter logic [15:0]          TIMEOUT   = 16'd50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // rx_valid is a one-cycle strobe with no backpressure; every strobe is consumed.
  typedef enum logic [2:0] {
    S_SYNC_WAIT = 3'd0,
    S_LEN_HI    = 3'd1,
    S_LEN_LO    = 3'd2,
    S_DATA      = 3'd3,
    S_CSUM      = 3'd4,
    S_RUN       = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_len_h;
  logic [12:0]         r_len;
  logic [12:0]         r_cnt;
  logic [7:0]          r_csum;
  logic [15:0]         r_timer;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_data;
  logic                r_mem_wr;
  logic                r_cpu_reset;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_active;
  logic                w_timeout;
  logic [12:0]         w_n;
  logic                w_len_bad;
  logic [7:0]          w_sum;
  logic                w_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_SYNC_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                  (r_state == S_DATA)   || (r_state == S_CSUM);
    w_timeout   = w_active && !rx_valid && (r_timer == (TIMEOUT - 16'd1));
    w_n         = {r_len_h[4:0], rx_data};
    // Image must fit between BASE_ADDR and the top of the address space.
    w_len_bad   = (r_len_h[7:5] != 3'd0) || (w_n == 13'd0) ||
                  ((32'(w_n) + 32'(BASE_ADDR)) > (32'd1 << ADDR_W));
    w_sum       = r_csum + rx_data;
    w_wr        = (r_state == S_DATA) && rx_valid && !reload;

    case (r_state)
      S_SYNC_WAIT: if (rx_valid && rx_data == SYNC) w_state_nxt = S_LEN_HI;
      S_LEN_HI:    if (rx_valid) w_state_nxt = S_LEN_LO;
      S_LEN_LO:    if (rx_valid) w_state_nxt = w_len_bad ? S_ERR : S_DATA;
      S_DATA:      if (rx_valid && r_cnt == r_len - 13'd1) w_state_nxt = S_CSUM;
      S_CSUM:      if (rx_valid) w_state_nxt = (w_sum == 8'h00) ? S_RUN : S_ERR;
      S_RUN:       w_state_nxt = S_RUN;
      S_ERR:       if (rx_valid && rx_data == SYNC) w_state_nxt = S_LEN_HI;
      default:     w_state_nxt = S_SYNC_WAIT;
    endcase

    if (w_timeout) w_state_nxt = S_ERR;
    if (reload)    w_state_nxt = S_SYNC_WAIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_h     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_timer     <= '0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_data  <= '0;
      r_mem_wr    <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (rx_valid) begin
        case (r_state)
          S_LEN_HI: r_len_h <= rx_data;
          S_LEN_LO: begin
            r_len  <= w_n;
            r_cnt  <= '0;
            r_csum <= '0;
          end
          S_DATA: begin
            r_cnt  <= r_cnt + 13'd1;
            r_csum <= w_sum;
          end
          default: ;
        endcase
      end

      if (!w_active || rx_valid || reload) r_timer <= '0;
      else                                 r_timer <= r_timer + 16'd1;

      r_mem_wr <= w_wr;
      if (w_wr) begin
        r_mem_addr <= BASE_ADDR + ADDR_W'(r_cnt);
        r_mem_data <= rx_data;
      end

      // Status flags are registered from the next state so they change with it.
      r_busy      <= (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                     (w_state_nxt == S_DATA)   || (w_state_nxt == S_CSUM);
      r_done      <= (w_state_nxt == S_RUN);
      r_err       <= (w_state_nxt == S_ERR);
      r_cpu_reset <= (w_state_nxt != S_RUN);
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_wr    = r_mem_wr;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued as bytes are sent
// and a negedge monitor pops them whenever mem_wr is seen.
module tb_prog_loader;

  localparam logic [15:0] TO = 16'd40;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];

  prog_loader #(.ADDR_W(13), .SYNC(8'hA5), .BASE_ADDR(13'h0000), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mem_wr) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          n_fail++;
          $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_data, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver tasks: called at posedge+1, each byte occupies exactly one cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic data_byte(input logic [12:0] a, input logic [7:0] b);
    exp_q.push_back({a, b});
    send_byte(b);
  endtask

  task automatic header(input logic [7:0] h, input logic [7:0] l);
    send_byte(8'hA5);
    send_byte(h);
    send_byte(l);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_data", 32'(mem_data), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
    check("rst_busy_done_err", 32'({busy, done, err}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    // noise then nominal load
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("noise_busy", 32'(busy), 32'h0);
    send_byte(8'hA5);
    check("sync_busy", 32'(busy), 32'h1);
    send_byte(8'h00); send_byte(8'h03);
    data_byte(13'h0000, 8'h11);
    data_byte(13'h0001, 8'h22);
    data_byte(13'h0002, 8'h33);
    check("nom_cpu_reset_before", 32'(cpu_reset), 32'h1);
    send_byte(8'h9A);
    check("nom_cpu_reset", 32'(cpu_reset), 32'h0);
    check("nom_done", 32'(done), 32'h1);
    check("nom_err_busy", 32'({err, busy}), 32'h0);
    send_byte(8'hA5);
    check("run_ignores_rx", 32'({done, busy}), 32'h2);

    pulse_reload();
    check("reload_cpu_reset", 32'(cpu_reset), 32'h1);
    check("reload_done", 32'(done), 32'h0);

    // bad checksum, then recovery from ERR
    header(8'h00, 8'h02);
    data_byte(13'h0000, 8'h01);
    data_byte(13'h0001, 8'h02);
    send_byte(8'h00);
    check("badsum_err", 32'(err), 32'h1);
    check("badsum_cpu_reset", 32'(cpu_reset), 32'h1);
    check("badsum_done", 32'(done), 32'h0);
    send_byte(8'hA5);
    check("err_clear_on_sync", 32'({err, busy}), 32'h1);
    send_byte(8'h00); send_byte(8'h01);
    data_byte(13'h0000, 8'h7F);
    send_byte(8'h81);
    check("recover_done", 32'(done), 32'h1);
    pulse_reload();

    // length checks
    header(8'h00, 8'h00);
    check("len_zero_err", 32'(err), 32'h1);
    header(8'h20, 8'h00);
    check("len_hibits_err", 32'(err), 32'h1);

    // maximum image: 8191 bytes ending at 1FFE
    header(8'h1F, 8'hFF);
    sum = 8'h00;
    for (int i = 0; i < 8191; i++) begin
      b = 8'(i) ^ 8'h3C;
      sum = sum + b;
      data_byte(13'(i), b);
    end
    check("max_last_addr", 32'(mem_addr), 32'h1FFE);
    check("max_not_done_yet", 32'(done), 32'h0);
    send_byte(8'h00 - sum);
    check("max_done", 32'(done), 32'h1);
    pulse_reload();

    // timeout fires exactly TO cycles after the last byte
    header(8'h00, 8'h02);
    data_byte(13'h0000, 8'h55);
    idle(int'(TO) - 1);
    check("timeout_not_yet", 32'(err), 32'h0);
    idle(1);
    check("timeout_err", 32'(err), 32'h1);

    // a byte arriving on the last allowed cycle keeps the frame alive
    header(8'h00, 8'h02);
    data_byte(13'h0000, 8'h55);
    idle(int'(TO) - 1);
    data_byte(13'h0001, 8'h66);
    check("timeout_edge_no_err", 32'({err, busy}), 32'h1);
    send_byte(8'h45);
    check("timeout_edge_done", 32'(done), 32'h1);
    pulse_reload();

    // reload on the same cycle as a data byte
    header(8'h00, 8'h02);
    rx_data = 8'h77; rx_valid = 1'b1; reload = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; reload = 1'b0;
    check("reload_data_state", 32'(dbg_state), 32'h0);
    check("reload_data_no_wr", 32'({mem_wr, busy}), 32'h0);

    // asynchronous reset mid-DATA, then a clean load
    header(8'h00, 8'h03);
    data_byte(13'h0000, 8'h10);
    send_byte(8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 32'h0);
    check("arst_mem_addr", 32'(mem_addr), 32'h0);
    check("arst_mem_data", 32'(mem_data), 32'h0);
    check("arst_flags", 32'({cpu_reset, busy, done, err}), 32'h8);
    check("arst_state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    header(8'h00, 8'h02);
    data_byte(13'h0000, 8'hAB);
    data_byte(13'h0001, 8'hCD);
    send_byte(8'h88);
    check("post_arst_done", 32'({done, cpu_reset, err}), 32'h4);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the cpu core.
- Receives a framed byte stream from a serial receiver and writes it into the 8K x 8 program/data memory on the cpu's 13-bit address / 8-bit data bus.
- Holds the cpu in reset while loading and releases it only after a checksum-verified image is in memory.

Parameters:
- ADDR_W, 13, memory address width (matches the cpu address bus).
- SYNC, 8'hA5, frame start byte.
- BASE_ADDR, 13'h0000, address of the first image byte.
- TIMEOUT, 16'd50000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears the whole block.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- reload  in  1  one-cycle pulse; re-enter load mode from any state.
- mem_addr  out  13  memory write address.
- mem_data  out  8  memory write data.
- mem_wr  out  1  one-cycle write strobe.
- cpu_reset  out  1  active-high reset to the cpu (matches the cpu's reset polarity).
- busy  out  1  frame in progress.
- done  out  1  image loaded and verified; cpu running.
- err  out  1  frame rejected.

Behaviour:
- Reset values: state=SYNC_WAIT, mem_addr=BASE_ADDR, mem_data=0, mem_wr=0, cpu_reset=1, busy=0, done=0, err=0, internal length/count/checksum/timer=0.
- Frame format: SYNC, LEN_H, LEN_L, N data bytes, CSUM.
  - N = {LEN_H[4:0], LEN_L}.
  - Valid when sum(data) + CSUM == 8'h00, 8-bit wrap.
- A byte is accepted only on a cycle with rx_valid=1; no backpressure.
- States and transitions:
  - SYNC_WAIT: rx_data==SYNC -> LEN_HI, busy=1, err=0. Any other byte is ignored.
  - LEN_HI: latch the high length byte -> LEN_LO.
  - LEN_LO: form N. Go to ERR if any of: LEN_H[7:5]!=0, N==0, or BASE_ADDR+N > 2^ADDR_W. Otherwise -> DATA with count=0 and checksum=0.
  - DATA: each byte is registered into mem_data, with mem_addr=BASE_ADDR+count and mem_wr=1 for exactly one cycle, 1 cycle after the rx_valid cycle. Then count++ and checksum+=byte. When count reaches N -> CSUM.
  - CSUM: if (checksum+byte)==0 -> RUN, else -> ERR.
  - RUN: cpu_reset=0 from the cycle after the CSUM byte; done=1, busy=0. All rx bytes are ignored.
  - ERR: err=1, busy=0, cpu_reset=1. A SYNC byte -> LEN_HI (err clears); other bytes are ignored.
- Timeout:
  - The timer resets on every accepted byte while in LEN_HI, LEN_LO, DATA or CSUM, and increments otherwise in those states.
  - Timer==TIMEOUT-1 with no byte -> ERR next cycle.
  - The timer is idle in SYNC_WAIT, RUN and ERR.
- reload (highest priority over rx_valid in the same cycle): from any state, next cycle -> SYNC_WAIT, cpu_reset=1, done=0, err=0, busy=0, mem_wr=0.
- Memory contents already written by a rejected frame are not rolled back. The cpu stays in reset, so they are harmless.
- mem_addr holds its last value when mem_wr=0.
- Asynchronous reset mid-frame: everything returns to reset values immediately. A partially written image remains in memory.

Test Plan:
- Nominal load: A5,00,03,11,22,33,9A -> mem_wr pulses writing 0000=11, 0001=22, 0002=33 on consecutive accepted bytes. cpu_reset falls 1 cycle after the 9A byte; done=1, err=0.
- Bad checksum: A5,00,02,01,02,00 -> two writes, then err=1, cpu_reset stays 1, done=0. Then A5,00,01,7F,81 -> err clears, 0000=7F, done=1.
- Length checks: A5,00,00 -> ERR with no mem_wr. A5,20,00 -> ERR. A5,1F,FF followed by a full 8191-byte stream with a correct checksum -> last write at 1FFE, done=1.
- Timeout: A5,00,02,55, then idle for TIMEOUT cycles -> err=1 exactly TIMEOUT cycles after the 55 byte. Idle of TIMEOUT-1 cycles then the next byte -> no error.
- reload in RUN: after a successful load, pulse reload -> cpu_reset=1 and done=0 next cycle. reload on the same cycle as an rx_valid data byte -> no mem_wr, state SYNC_WAIT.
- Noise and async reset: bytes 00,FF,5A before A5 are ignored. Assert reset low mid-DATA -> outputs go to reset values immediately; a subsequent full frame loads correctly.
